decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Supports active-low or active-high outputs and a global enable.
- Adds a built-in scan engine with a prescaler, so the block can drive LED/digit banks on its own. Modes: direct decode, walk up, walk down, bounce.
- Sits between board switches/control logic and LEDR-style output banks. Successor to the fixed 2-4/3-8/4-16 active-low decoders.

Parameters:
- N_SEL, 4: select width; output width OUT_W = 2**N_SEL; legal range 1..6.
- ACTIVE_LOW, 1: 1 = asserted output bit is 0 and idle bits are 1; 0 = asserted bit is 1 and idle bits are 0.
- SCAN_DIV, 25: clock cycles per scan step; legal range ≥1; prescaler width = clog2(SCAN_DIV), minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; 0 forces all outputs inactive and freezes index
- mode  in  2  00 direct, 01 scan up, 10 scan down, 11 bounce
- sel  in  N_SEL  direct select / load value
- load  in  1  scan modes: idx <= sel this cycle (ignored in direct mode)
- y  out  OUT_W  registered one-hot (polarity per ACTIVE_LOW)
- idx  out  N_SEL  registered current index
- step  out  1  one-cycle pulse, registered, when scan advanced idx

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values, taking effect at the rising edge with rst=1:
  - idx=0, dir=up, div_cnt=0, step=0.
  - y = all inactive: all 1s if ACTIVE_LOW, else all 0s.
  - rst overrides every other input.
  - Reset mid-scan discards progress; the next step comes SCAN_DIV enabled cycles after rst deasserts.
- Consistency: y and idx update on the same edge, so y always equals decode(idx) while en was 1 at that edge.
- en=0: y <= all inactive; idx, dir hold; div_cnt <= 0; step <= 0. Load is ignored.
- en=1, mode=00 (direct):
  - idx <= sel and y <= decode(sel); latency is 1 clock.
  - div_cnt <= 0, step <= 0.
- en=1, scan modes, prescaler:
  - tick = (div_cnt == SCAN_DIV-1).
  - div_cnt wraps to 0 on tick, else increments.
  - If SCAN_DIV=1, tick is true every cycle.
- load=1 in scan mode:
  - idx <= sel, div_cnt <= 0, step <= 0.
  - load has priority over tick.
  - dir unchanged, except in bounce: load of OUT_W-1 sets dir=down, load of 0 sets dir=up.
- tick in mode 01: idx <= idx+1, wrapping from OUT_W-1 to 0; step <= 1.
- tick in mode 10: idx <= idx-1, wrapping from 0 to OUT_W-1; step <= 1.
- tick in mode 11 (bounce):
  - dir=up and idx<OUT_W-1: idx+1.
  - dir=up and idx==OUT_W-1: dir<=down, idx<=OUT_W-2.
  - dir=down and idx>0: idx-1.
  - dir=down and idx==0: dir<=up, idx<=1.
  - Endpoints are shown once per pass (no dwell); step <= 1.
- No tick and no load: idx holds, step <= 0.
- Mode change:
  - div_cnt is not cleared between scan modes; the index continues from its current value.
  - Entering direct mode clears div_cnt.
  - Leaving direct mode starts from idx = last sel, and the first tick occurs SCAN_DIV cycles later.
  - dir persists across modes; only bounce and load modify it.
- Width rules: idx arithmetic is modulo 2^N_SEL; no out-of-range index exists.

Test Plan (N_SEL=4, SCAN_DIV=4, ACTIVE_LOW=1 unless noted):
- Reset: rst=1 for 2 cycles with en=1, mode=01 -> y=16'hFFFF, idx=0, step=0. First step pulse appears on the 4th enabled edge after rst falls; then idx=1, y=16'hFFFD.
- Direct decode: en=1, mode=00, sel sweeps 0..15 one per cycle -> each following cycle y = ~(1<<sel), e.g. sel=9 gives y=16'hFDFF. step stays 0. Repeat with ACTIVE_LOW=0: sel=9 gives y=16'h0200.
- Scan wrap: mode=01 from idx=14 -> idx 15 then 0 at 4-cycle spacing, step pulses once per advance. mode=10 from idx=1 -> 0 then 15.
- Bounce: mode=11, load sel=13 -> idx sequence 13,14,15,14,13…1,0,1 with no repeated endpoints. load sel=15 then tick -> idx=14 (dir down).
- Enable/load priority: during scan, en=0 for 3 cycles -> y=16'hFFFF, idx frozen, next step 4 cycles after en returns. load=1 coinciding with tick and sel=7 -> idx=7, step=0.
- Mid-operation reset: rst asserted while idx=9 and div_cnt=2 in bounce with dir=down -> next cycle idx=0, dir=up, y=16'hFFFF. Resumed bounce goes 0,1,2.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered N_SEL-to-2^N_SEL one-hot decoder with a built-in
// scan engine (direct, walk up, walk down, bounce) paced by a prescaler.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst   - synchronous, active-high reset
//   en    - enable; 0 blanks y, freezes idx/dir, clears the prescaler
//   mode  - 00 direct, 01 scan up, 10 scan down, 11 bounce
//   sel   - direct select / scan load value
//   load  - scan modes only: idx <= sel this cycle
//   y     - registered one-hot output, polarity set by ACTIVE_LOW
//   idx   - registered current index
//   step  - registered one-cycle pulse when the scan advanced idx
module decoder_scan #(
  parameter int unsigned N_SEL      = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned SCAN_DIV   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [N_SEL-1:0]      sel,
  input  logic                  load,
  output logic [(2**N_SEL)-1:0] y,
  output logic [N_SEL-1:0]      idx,
  output logic                  step
);

  localparam int unsigned OUT_W = 2 ** N_SEL;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [N_SEL-1:0] IDX_MAX  = N_SEL'(OUT_W - 1);
  localparam logic [N_SEL-1:0] IDX_MIN  = '0;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] Y_IDLE   = {OUT_W{1'(ACTIVE_LOW != 0)}};

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  // Bounce direction is the only state beyond the index itself.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t             dir_q, dir_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [N_SEL-1:0] idx_nxt;
  logic             step_nxt;
  logic [OUT_W-1:0] y_nxt;
  logic [OUT_W-1:0] hot;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      dir_q   <= DIR_UP;
      div_cnt <= '0;
      step    <= 1'b0;
      y       <= Y_IDLE;
    end else begin
      idx     <= idx_nxt;
      dir_q   <= dir_nxt;
      div_cnt <= div_nxt;
      step    <= step_nxt;
      y       <= y_nxt;
    end
  end

  // Next-state: enable gating, direct decode, load, prescaled scan step.
  always_comb begin
    idx_nxt  = idx;
    dir_nxt  = dir_q;
    div_nxt  = '0;
    step_nxt = 1'b0;
    hot      = '0;
    y_nxt    = Y_IDLE;

    if (!en) begin
      // Hold index and direction; prescaler restarts when enabled again.
    end else if (mode == MODE_DIRECT) begin
      idx_nxt = sel;
    end else if (load) begin
      // Load beats tick and restarts the prescaler.
      idx_nxt = sel;
      if (mode == MODE_BOUNCE) begin
        if (sel == IDX_MAX) begin
          dir_nxt = DIR_DOWN;
        end else if (sel == IDX_MIN) begin
          dir_nxt = DIR_UP;
        end
      end
    end else begin
      div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        step_nxt = 1'b1;
        case (mode)
          MODE_UP:   idx_nxt = idx + N_SEL'(1);
          MODE_DOWN: idx_nxt = idx - N_SEL'(1);
          MODE_BOUNCE: begin
            // Turn around at the ends without repeating the endpoint.
            if (dir_q == DIR_UP) begin
              if (idx == IDX_MAX) begin
                dir_nxt = DIR_DOWN;
                idx_nxt = idx - N_SEL'(1);
              end else begin
                idx_nxt = idx + N_SEL'(1);
              end
            end else begin
              if (idx == IDX_MIN) begin
                dir_nxt = DIR_UP;
                idx_nxt = idx + N_SEL'(1);
              end else begin
                idx_nxt = idx - N_SEL'(1);
              end
            end
          end
          default: idx_nxt = idx;
        endcase
      end
    end

    // y tracks the new index on the same edge.
    if (en) begin
      hot   = OUT_W'(1) << idx_nxt;
      y_nxt = (ACTIVE_LOW != 0) ? ~hot : hot;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Testbench for decoder_scan: table-driven cycle vectors plus directed
// sequences for bounce turn-around, load, mid-scan reset and direct decode.
module tb_decoder_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic        load;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        step;
  logic [15:0] y_hi;
  logic [3:0]  idx_hi;
  logic        step_hi;

  int unsigned n_checks;
  int unsigned n_fail;

  decoder_scan #(.N_SEL(4), .ACTIVE_LOW(1), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y), .idx(idx), .step(step)
  );

  decoder_scan #(.N_SEL(4), .ACTIVE_LOW(0), .SCAN_DIV(4)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y_hi), .idx(idx_hi), .step(step_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic        load;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        step;
  } vec_t;

  vec_t vecs[28];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [15:0] ey, input logic [3:0] ei,
                       input logic es);
    cmp({nm, ".y"}, 32'(y), 32'(ey));
    cmp({nm, ".idx"}, 32'(idx), 32'(ei));
    cmp({nm, ".step"}, 32'(step), 32'(es));
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0]  e_idx;
  logic        e_dir;
  logic [15:0] e_hot;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b1; mode = 2'b01; sel = 4'd0; load = 1'b0;

    //          n  rst en mode   sel  ld  y         idx  step
    vecs[0]  = '{2, 1, 1, 2'b01, 4'd0, 0, 16'hFFFF, 4'd0,  0};
    vecs[1]  = '{3, 0, 1, 2'b01, 4'd0, 0, 16'hFFFE, 4'd0,  0};
    vecs[2]  = '{1, 0, 1, 2'b01, 4'd0, 0, 16'hFFFD, 4'd1,  1};
    // scan up wrap 14 -> 15 -> 0
    vecs[3]  = '{1, 0, 1, 2'b01, 4'd14, 1, 16'hBFFF, 4'd14, 0};
    vecs[4]  = '{3, 0, 1, 2'b01, 4'd0, 0, 16'hBFFF, 4'd14, 0};
    vecs[5]  = '{1, 0, 1, 2'b01, 4'd0, 0, 16'h7FFF, 4'd15, 1};
    vecs[6]  = '{3, 0, 1, 2'b01, 4'd0, 0, 16'h7FFF, 4'd15, 0};
    vecs[7]  = '{1, 0, 1, 2'b01, 4'd0, 0, 16'hFFFE, 4'd0,  1};
    // scan down wrap 1 -> 0 -> 15
    vecs[8]  = '{1, 0, 1, 2'b10, 4'd1, 1, 16'hFFFD, 4'd1,  0};
    vecs[9]  = '{3, 0, 1, 2'b10, 4'd0, 0, 16'hFFFD, 4'd1,  0};
    vecs[10] = '{1, 0, 1, 2'b10, 4'd0, 0, 16'hFFFE, 4'd0,  1};
    vecs[11] = '{3, 0, 1, 2'b10, 4'd0, 0, 16'hFFFE, 4'd0,  0};
    vecs[12] = '{1, 0, 1, 2'b10, 4'd0, 0, 16'h7FFF, 4'd15, 1};
    // enable drop mid-prescale restarts the prescaler
    vecs[13] = '{2, 0, 1, 2'b01, 4'd0, 0, 16'h7FFF, 4'd15, 0};
    vecs[14] = '{3, 0, 0, 2'b01, 4'd0, 0, 16'hFFFF, 4'd15, 0};
    vecs[15] = '{3, 0, 1, 2'b01, 4'd0, 0, 16'h7FFF, 4'd15, 0};
    vecs[16] = '{1, 0, 1, 2'b01, 4'd0, 0, 16'hFFFE, 4'd0,  1};
    // load coinciding with tick wins
    vecs[17] = '{3, 0, 1, 2'b01, 4'd0, 0, 16'hFFFE, 4'd0,  0};
    vecs[18] = '{1, 0, 1, 2'b01, 4'd7, 1, 16'hFF7F, 4'd7,  0};
    vecs[19] = '{3, 0, 1, 2'b01, 4'd0, 0, 16'hFF7F, 4'd7,  0};
    vecs[20] = '{1, 0, 1, 2'b01, 4'd0, 0, 16'hFEFF, 4'd8,  1};
    // load ignored while disabled
    vecs[21] = '{1, 0, 0, 2'b01, 4'd3, 1, 16'hFFFF, 4'd8,  0};
    vecs[22] = '{1, 0, 1, 2'b01, 4'd0, 0, 16'hFEFF, 4'd8,  0};
    // bounce from 13 up through 15 and back
    vecs[23] = '{1, 0, 1, 2'b11, 4'd13, 1, 16'hDFFF, 4'd13, 0};
    vecs[24] = '{4, 0, 1, 2'b11, 4'd0, 0, 16'hBFFF, 4'd14, 1};
    vecs[25] = '{4, 0, 1, 2'b11, 4'd0, 0, 16'h7FFF, 4'd15, 1};
    vecs[26] = '{4, 0, 1, 2'b11, 4'd0, 0, 16'hBFFF, 4'd14, 1};
    vecs[27] = '{4, 0, 1, 2'b11, 4'd0, 0, 16'hDFFF, 4'd13, 1};

    for (int i = 0; i < 28; i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      mode = vecs[i].mode;
      sel  = vecs[i].sel;
      load = vecs[i].load;
      run(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].step);
    end

    // Bounce continues down to 0 and turns back up: 12..0,1,2
    load = 1'b0; sel = 4'd0; mode = 2'b11;
    e_idx = 4'd13;
    e_dir = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (!e_dir) begin
        if (e_idx == 4'd15) begin e_dir = 1'b1; e_idx = 4'd14; end
        else e_idx = e_idx + 4'd1;
      end else begin
        if (e_idx == 4'd0) begin e_dir = 1'b0; e_idx = 4'd1; end
        else e_idx = e_idx - 4'd1;
      end
      run(4);
      e_hot = 16'h1 << e_idx;
      check($sformatf("bounce%0d", k), ~e_hot, e_idx, 1'b1);
    end

    // Load of top endpoint in bounce sets direction down
    load = 1'b1; sel = 4'd15;
    run(1);
    check("load15", 16'h7FFF, 4'd15, 1'b0);
    load = 1'b0;
    run(4);
    check("load15_tick", 16'hBFFF, 4'd14, 1'b1);

    // Mid-scan reset at idx=9, div_cnt=2, dir=down
    load = 1'b1; sel = 4'd9;
    run(1);
    load = 1'b0;
    run(2);
    check("pre_rst", 16'hFDFF, 4'd9, 1'b0);
    rst = 1'b1;
    run(1);
    check("mid_rst", 16'hFFFF, 4'd0, 1'b0);
    rst = 1'b0;
    run(3);
    check("post_rst_hold", 16'hFFFE, 4'd0, 1'b0);
    run(1);
    check("post_rst_1", 16'hFFFD, 4'd1, 1'b1);
    run(4);
    check("post_rst_2", 16'hFFFB, 4'd2, 1'b1);

    // Direct decode sweep, both polarities
    mode = 2'b00;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      run(1);
      e_hot = 16'h1 << s;
      check($sformatf("direct%0d", s), ~e_hot, 4'(s), 1'b0);
      cmp($sformatf("direct_hi%0d.y", s), 32'(y_hi), 32'(e_hot));
    end
    sel = 4'd9;
    run(1);
    cmp("direct9.y", 32'(y), 32'h0000FDFF);
    cmp("direct9_hi.y", 32'(y_hi), 32'h00000200);

    // Leaving direct mode: scan starts from last sel, first tick 4 cycles later
    mode = 2'b01;
    run(3);
    check("leave_direct_hold", 16'hFDFF, 4'd9, 1'b0);
    run(1);
    check("leave_direct_step", 16'hFBFF, 4'd10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
